// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage (opcodes, FSM states, widths).
// The optional barrel shifter is selected elsewhere with EX_BARREL_SHIFT_EN.
package ex_pkg;

    localparam int XLEN    = 64;
    localparam int RD_W    = 5;
    localparam int SHAMT_W = 6;

    // Codes 10..15 are reserved and produce a zero result.
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9
    } ex_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ex_state_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/ex_if.sv
// Decode-to-execute request channel and execute-to-writeback result slot.
// The stage uses the slave modport; the surrounding pipeline uses master.
interface ex_if;
    import ex_pkg::*;

    // Both channels: a transfer happens on a rising edge where valid && ready;
    // the sender holds valid and its payload stable until that edge, and ready
    // may depend combinationally on the receiver's own state.
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         in_op;
    logic [XLEN-1:0]    in_a;
    logic [XLEN-1:0]    in_b;
    logic [RD_W-1:0]    in_rd;

    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_result;
    logic [RD_W-1:0]    out_rd;
    logic               out_ov;

    modport master (
        output in_valid, in_op, in_a, in_b, in_rd, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_ov
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_rd, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_ov
    );

endinterface

// File: rtl/ex_shifter.sv
// Shift datapath: one-bit-per-cycle iterative shifter by default, or a purely
// combinational barrel shifter when EX_BARREL_SHIFT_EN is defined.
module ex_shifter
    import ex_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [3:0]         op,
    input  logic [XLEN-1:0]    a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [XLEN-1:0]    imm_result,
    output logic [XLEN-1:0]    iter_result,
    output logic               last
);

`ifdef EX_BARREL_SHIFT_EN

    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n, load, step};

    always_comb begin
        imm_result = a;
        case (op)
            OP_SLL:  imm_result = a << shamt;
            OP_SRL:  imm_result = a >> shamt;
            OP_SRA:  imm_result = $unsigned($signed(a) >>> shamt);
            default: imm_result = a;
        endcase
    end

    assign iter_result = '0;
    assign last        = 1'b0;

`else

    logic [XLEN-1:0]    sh_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [3:0]         op_q;

    function automatic logic [XLEN-1:0] shift1(input logic [3:0] o, input logic [XLEN-1:0] v);
        case (o)
            OP_SLL:  return {v[XLEN-2:0], 1'b0};
            OP_SRA:  return {v[XLEN-1], v[XLEN-1:1]};
            default: return {1'b0, v[XLEN-1:1]};
        endcase
    endfunction

    // The last bit of shift happens on the way into the output slot, so the
    // register stops one step short and waits there while the slot is busy.
    assign last        = (cnt_q == SHAMT_W'(1));
    assign iter_result = shift1(op_q, sh_q);
    assign imm_result  = a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            cnt_q <= '0;
            op_q  <= '0;
        end else if (load) begin
            sh_q  <= a;
            cnt_q <= shamt;
            op_q  <= op;
        end else if (step && !last) begin
            sh_q  <= shift1(op_q, sh_q);
            cnt_q <= cnt_q - SHAMT_W'(1);
        end
    end

`endif

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, shift sequencing FSM and a single registered result slot.
// Define EX_BARREL_SHIFT_EN to compute shifts in one cycle and drop the SHIFT state.
module ex_stage
    import ex_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    input  logic      ov_clr,
    ex_if.slave       io,
    output logic      ov_sticky,
    output logic      busy,
    output ex_state_e state_dbg
);

    ex_state_e          state_q;
    ex_state_e          state_d;
    logic               slot_free;
    logic               accept;
    logic               start_iter;
    logic               alu_load;
    logic               sh_done;
    logic               sh_step;
    logic               sh_last;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    sh_imm;
    logic [XLEN-1:0]    sh_iter;
    logic [XLEN-1:0]    sum;
    logic [XLEN-1:0]    diff;
    logic [XLEN-1:0]    alu_res;
    logic               alu_ov;
    logic [RD_W-1:0]    sh_rd_q;

    assign slot_free   = !io.out_valid || io.out_ready;
    assign io.in_ready = !flush && (state_q == ST_IDLE) && slot_free;
    assign accept      = io.in_valid && io.in_ready;
    assign shamt       = io.in_b[SHAMT_W-1:0];

`ifdef EX_BARREL_SHIFT_EN
    assign start_iter = 1'b0;
`else
    assign start_iter = accept && is_shift_op(io.in_op) && (shamt != '0);
`endif

    assign alu_load = accept && !start_iter;
    assign sh_step  = (state_q == ST_SHIFT) && !flush;
    assign sh_done  = sh_step && sh_last && slot_free;

    ex_shifter u_shifter (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (start_iter),
        .step        (sh_step),
        .op          (io.in_op),
        .a           (io.in_a),
        .shamt       (shamt),
        .imm_result  (sh_imm),
        .iter_result (sh_iter),
        .last        (sh_last)
    );

    assign sum  = io.in_a + io.in_b;
    assign diff = io.in_a + ~io.in_b + XLEN'(1);

    always_comb begin
        alu_res = '0;
        alu_ov  = 1'b0;
        case (io.in_op)
            OP_ADD: begin
                alu_res = sum;
                alu_ov  = (io.in_a[XLEN-1] == io.in_b[XLEN-1]) && (sum[XLEN-1] != io.in_a[XLEN-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ov  = (io.in_a[XLEN-1] != io.in_b[XLEN-1]) && (diff[XLEN-1] != io.in_a[XLEN-1]);
            end
            OP_AND:  alu_res = io.in_a & io.in_b;
            OP_OR:   alu_res = io.in_a | io.in_b;
            OP_XOR:  alu_res = io.in_a ^ io.in_b;
            OP_SLT:  alu_res = XLEN'($signed(io.in_a) < $signed(io.in_b));
            OP_SLTU: alu_res = XLEN'(io.in_a < io.in_b);
            OP_SLL, OP_SRL, OP_SRA: alu_res = sh_imm;
            default: alu_res = '0;
        endcase
    end

`ifdef EX_BARREL_SHIFT_EN
    assign state_q = ST_IDLE;
    assign state_d = ST_IDLE;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_iter) state_d = ST_SHIFT;
            ST_SHIFT: if (flush || sh_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end
`endif

    assign busy      = (state_q == ST_SHIFT);
    assign state_dbg = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sh_rd_q <= '0;
        else if (start_iter) sh_rd_q <= io.in_rd;
    end

    // A load only happens when the slot is free or draining, so a same-cycle
    // drain is covered by simply overwriting the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io.out_valid  <= 1'b0;
            io.out_result <= '0;
            io.out_rd     <= '0;
            io.out_ov     <= 1'b0;
        end else if (flush) begin
            io.out_valid <= 1'b0;
        end else if (sh_done) begin
            io.out_valid  <= 1'b1;
            io.out_result <= sh_iter;
            io.out_rd     <= sh_rd_q;
            io.out_ov     <= 1'b0;
        end else if (alu_load) begin
            io.out_valid  <= 1'b1;
            io.out_result <= alu_res;
            io.out_rd     <= io.in_rd;
            io.out_ov     <= alu_ov;
        end else if (io.out_ready) begin
            io.out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                         ov_sticky <= 1'b0;
        else if (ov_clr)                                    ov_sticky <= 1'b0;
        else if (io.out_valid && io.out_ready && io.out_ov) ov_sticky <= 1'b1;
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; expectations adapt when
// EX_BARREL_SHIFT_EN is defined.
module tb_ex_stage;
    import ex_pkg::*;

`ifdef EX_BARREL_SHIFT_EN
    localparam bit ITER = 1'b0;
`else
    localparam bit ITER = 1'b1;
`endif

    logic      clk;
    logic      rst_n;
    logic      flush;
    logic      ov_clr;
    logic      ov_sticky;
    logic      busy;
    ex_state_e state_dbg;

    ex_if bus();

    ex_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .ov_clr    (ov_clr),
        .io        (bus),
        .ov_sticky (ov_sticky),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard
    int n_total = 0;
    int n_bad   = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // driver tasks: all driving and sampling happens just after a rising edge
    task automatic send(input string tag, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_rd    = rd;
        #1;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [63:0] res, input logic [4:0] rd,
                        input logic ov, input int exp_wait);
        int n;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(exp_wait));
        check({tag, "_vld"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_res"}, bus.out_result, res);
        check({tag, "_rd"},  64'(bus.out_rd), 64'(rd));
        check({tag, "_ov"},  64'(bus.out_ov), 64'(ov));
        @(posedge clk); #1;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_vld"},    64'(bus.out_valid), 64'd0);
        check({tag, "_res"},    bus.out_result,     64'd0);
        check({tag, "_rd"},     64'(bus.out_rd),    64'd0);
        check({tag, "_ov"},     64'(bus.out_ov),    64'd0);
        check({tag, "_sticky"}, 64'(ov_sticky),     64'd0);
        check({tag, "_busy"},   64'(busy),          64'd0);
        check({tag, "_state"},  64'(state_dbg),     64'(ST_IDLE));
    endtask

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        ov_clr        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_rd     = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        reset_checks("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // signed overflow and sticky flag
        send("add_ov", OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd3);
        recv("add_ov", 64'h8000_0000_0000_0000, 5'd3, 1'b1, 0);
        check("add_ov_sticky", 64'(ov_sticky), 64'd1);
        send("sub_ov", OP_SUB, 64'h8000_0000_0000_0000, 64'd1, 5'd4);
        recv("sub_ov", 64'h7FFF_FFFF_FFFF_FFFF, 5'd4, 1'b1, 0);

        // compares, bitwise, reserved opcode
        send("slt",  OP_SLT,  '1, 64'd1, 5'd5);
        recv("slt",  64'd1, 5'd5, 1'b0, 0);
        send("sltu", OP_SLTU, '1, 64'd1, 5'd6);
        recv("sltu", 64'd0, 5'd6, 1'b0, 0);
        send("add0", OP_ADD,  '1, 64'd1, 5'd7);
        recv("add0", 64'd0, 5'd7, 1'b0, 0);
        send("and",  OP_AND, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 5'd8);
        recv("and",  64'hF000_F000_F000_F000, 5'd8, 1'b0, 0);
        send("or",   OP_OR,  64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 5'd9);
        recv("or",   64'hFFF0_FFF0_FFF0_FFF0, 5'd9, 1'b0, 0);
        send("xor",  OP_XOR, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 5'd10);
        recv("xor",  64'h0FF0_0FF0_0FF0_0FF0, 5'd10, 1'b0, 0);
        send("rsvd", 4'd12, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd11);
        recv("rsvd", 64'd0, 5'd11, 1'b0, 0);

        // throughput: one ALU op per cycle with in_valid held
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_op    = OP_ADD;
            bus.in_a     = 64'(i * 3);
            bus.in_b     = 64'd100;
            bus.in_rd    = 5'(i);
            exp_q.push_back(64'(i * 3 + 100));
            #1;
            check("tput_rdy", 64'(bus.in_ready), 64'd1);
            @(posedge clk); #1;
            check("tput_vld", 64'(bus.out_valid), 64'd1);
            check("tput_res", bus.out_result, exp_q.pop_front());
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("tput_drain", 64'(bus.out_valid), 64'd0);

        // shifts
        send("sra63", OP_SRA, 64'h8000_0000_0000_0000, 64'd63, 5'd12);
        check("sra63_busy", 64'(busy), 64'(ITER));
        check("sra63_inrdy", 64'(bus.in_ready), 64'(!ITER));
        recv("sra63", 64'hFFFF_FFFF_FFFF_FFFF, 5'd12, 1'b0, ITER ? 63 : 0);
        check("sra63_idle", 64'(busy), 64'd0);
        send("sll4", OP_SLL, 64'd1, 64'hFFFF_FFFF_FFFF_FF04, 5'd13);
        recv("sll4", 64'h10, 5'd13, 1'b0, ITER ? 4 : 0);
        send("srl1", OP_SRL, 64'h8000_0000_0000_0000, 64'd1, 5'd14);
        recv("srl1", 64'h4000_0000_0000_0000, 5'd14, 1'b0, ITER ? 1 : 0);
        send("sll0", OP_SLL, 64'h1234, 64'd64, 5'd15);
        check("sll0_busy", 64'(busy), 64'd0);
        recv("sll0", 64'h1234, 5'd15, 1'b0, 0);

        // backpressure, then load and drain in the same cycle
        bus.out_ready = 1'b0;
        send("bp", OP_ADD, 64'd5, 64'd6, 5'd7);
        bus.in_valid = 1'b1;
        bus.in_op    = OP_XOR;
        bus.in_a     = 64'd3;
        bus.in_b     = 64'd5;
        bus.in_rd    = 5'd9;
        for (int i = 0; i < 5; i++) begin
            check("bp_inrdy", 64'(bus.in_ready), 64'd0);
            check("bp_vld",   64'(bus.out_valid), 64'd1);
            check("bp_res",   bus.out_result, 64'd11);
            check("bp_rd",    64'(bus.out_rd), 64'd7);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_rel_rdy", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp_next_vld", 64'(bus.out_valid), 64'd1);
        check("bp_next_res", bus.out_result, 64'd6);
        check("bp_next_rd",  64'(bus.out_rd), 64'd9);
        @(posedge clk); #1;

        // flush mid-shift
        send("fl", OP_SLL, 64'd1, 64'd10, 5'd2);
        repeat (3) @(posedge clk);
        #1;
        check("fl_busy_pre", 64'(busy), 64'(ITER));
        flush = 1'b1;
        #1;
        check("fl_inrdy", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("fl_busy",  64'(busy), 64'd0);
        check("fl_state", 64'(state_dbg), 64'(ST_IDLE));
        check("fl_vld",   64'(bus.out_valid), 64'd0);
        repeat (12) @(posedge clk);
        #1;
        check("fl_vld_late", 64'(bus.out_valid), 64'd0);

        // ov_clr wins over a same-cycle set
        ov_clr = 1'b1;
        @(posedge clk); #1;
        ov_clr = 1'b0;
        check("clr_sticky", 64'(ov_sticky), 64'd0);
        bus.out_ready = 1'b0;
        send("clrset", OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd1);
        check("clrset_ov", 64'(bus.out_ov), 64'd1);
        bus.out_ready = 1'b1;
        ov_clr        = 1'b1;
        @(posedge clk); #1;
        ov_clr = 1'b0;
        check("clrset_sticky", 64'(ov_sticky), 64'd0);
        check("clrset_vld",    64'(bus.out_valid), 64'd0);

        // flush leaves the sticky flag alone
        send("flst", OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd1);
        recv("flst", 64'h8000_0000_0000_0000, 5'd1, 1'b1, 0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flst_sticky", 64'(ov_sticky), 64'd1);

        // asynchronous reset in the middle of a shift
        bus.out_ready = 1'b0;
        send("arst", OP_SRA, 64'h8000_0000_0000_0000, 64'd63, 5'd20);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        reset_checks("arst");
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        rst_n         = 1'b1;
        @(posedge clk); #1;
        check("arst_inrdy", 64'(bus.in_ready), 64'd1);
        check("arst_vld",   64'(bus.out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
